// File: rtl/jpeg_seq_pkg.sv
// Shared types and constants for the JPEG accelerator's DCT sequencing logic.
package jpeg_seq_pkg;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} dct_state_t;
  localparam int ROWS  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dct2d_seq_slot_counter.sv
// Slot/row counter pair: cnt walks the clocks of one 1-D DCT slot, idx walks rows/columns.
module slot_counter
  import jpeg_seq_pkg::*;
#(
  parameter int CYCLES_PER_ROW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             slot_last,
  output logic             blk_last
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_ROW - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ROWS - 1);

  assign slot_last = (cnt == CNT_MAX);
  assign blk_last  = slot_last && (idx == IDX_MAX);

  // idx only returns to 0 through clr, which the owner raises on every state change
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (slot_last) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dct2d_seq.sv
// Two-pass 8x8 DCT sequencer: rows into the transpose memory, then columns out to the output buffer.
module dct2d_seq
  import jpeg_seq_pkg::*;
#(
  parameter int CYCLES_PER_ROW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  input  logic             out_free,
  input  logic             abort,
  output logic             busy,
  output logic [IDX_W-1:0] in_row_addr,
  output logic             dct_sel,
  output logic             t_wr,
  output logic             t_rd,
  output logic [IDX_W-1:0] out_col_addr,
  output logic             out_we,
  output logic             blk_ack,
  output logic             done
);
  dct_state_t       state;
  logic             start, leave, in_pass;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_last, blk_last;
  logic             cnt_unused;

  assign start   = blk_valid && out_free;
  assign in_pass = (state == PASS1) || (state == PASS2);

  // leave is high exactly when the FSM below changes state, so counters restart on entry
  always_comb begin
    leave = 1'b0;
    case (state)
      IDLE:         leave = start;
      PASS1, PASS2: leave = blk_last;
      DONE:         leave = 1'b1;
      default:      leave = 1'b0;
    endcase
  end

  slot_counter #(.CYCLES_PER_ROW(CYCLES_PER_ROW)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .clr       (abort || leave),
    .en        (in_pass),
    .cnt       (cnt),
    .idx       (idx),
    .slot_last (slot_last),
    .blk_last  (blk_last)
  );

  // the raw slot count is only consumed through slot_last/blk_last
  assign cnt_unused = ^cnt;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= PASS1;
        PASS1:   if (blk_last) state <= PASS2;
        PASS2:   if (blk_last) state <= DONE;
        DONE:    state <= start ? PASS1 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign dct_sel      = (state == PASS2);
  assign in_row_addr  = (state == PASS1) ? idx : '0;
  assign out_col_addr = (state == PASS2) ? idx : '0;
  assign t_wr         = (state == PASS1) && slot_last;
  assign t_rd         = (state == PASS2) && slot_last;
  assign out_we       = (state == PASS2) && slot_last;
  assign blk_ack      = (state == PASS1) && blk_last;
  assign done         = (state == DONE);
endmodule

// File: tb/tb_dct2d_seq.sv
// Directed bench for dct2d_seq: default (4) and CYCLES_PER_ROW=2 instances driven in lockstep.
module tb_dct2d_seq;
  logic clk = 1'b0;
  logic rst, blk_valid, out_free, abort;

  logic       busy, dct_sel, t_wr, t_rd, out_we, blk_ack, done;
  logic [2:0] in_row_addr, out_col_addr;
  logic       busy2, dct_sel2, t_wr2, t_rd2, out_we2, blk_ack2, done2;
  logic [2:0] in_row_addr2, out_col_addr2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dct2d_seq dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .out_free(out_free), .abort(abort),
    .busy(busy), .in_row_addr(in_row_addr), .dct_sel(dct_sel), .t_wr(t_wr), .t_rd(t_rd),
    .out_col_addr(out_col_addr), .out_we(out_we), .blk_ack(blk_ack), .done(done)
  );

  dct2d_seq #(.CYCLES_PER_ROW(2)) dut_c2 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .out_free(out_free), .abort(abort),
    .busy(busy2), .in_row_addr(in_row_addr2), .dct_sel(dct_sel2), .t_wr(t_wr2), .t_rd(t_rd2),
    .out_col_addr(out_col_addr2), .out_we(out_we2), .blk_ack(blk_ack2), .done(done2)
  );

  logic [12:0] v1, v2;
  assign v1 = {busy, dct_sel, in_row_addr, out_col_addr, t_wr, t_rd, out_we, blk_ack, done};
  assign v2 = {busy2, dct_sel2, in_row_addr2, out_col_addr2, t_wr2, t_rd2, out_we2, blk_ack2, done2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output vector k cycles after the start was sampled (k<=0 or past done: idle).
  function automatic logic [12:0] exp_vec(input int k, input int c);
    logic [2:0] idx;
    logic       last;
    int         p;
    exp_vec = '0;
    if (k >= 1 && k <= 8*c) begin
      p = k - 1;
      idx = 3'(p / c);
      last = (p % c) == c - 1;
      exp_vec = {1'b1, 1'b0, idx, 3'b0, last, 1'b0, 1'b0, last && idx == 3'd7, 1'b0};
    end else if (k > 8*c && k <= 16*c) begin
      p = k - 1 - 8*c;
      idx = 3'(p / c);
      last = (p % c) == c - 1;
      exp_vec = {1'b1, 1'b1, 3'b0, idx, 1'b0, last, last, 1'b0, 1'b0};
    end else if (k == 16*c + 1) begin
      exp_vec = {1'b1, 1'b0, 3'b0, 3'b0, 5'b00001};
    end
  endfunction

  // Back-to-back: every 16*c+1 cycles a new block begins.
  function automatic logic [12:0] exp_b2b(input int k, input int c);
    int kk;
    kk = k;
    while (kk > 16*c + 1) kk -= 16*c + 1;
    return exp_vec(kk, c);
  endfunction

  task automatic cmp(input string tag, input int k1, input int k2, input bit b2b);
    check($sformatf("%s c4 k=%0d", tag, k1), v1, b2b ? exp_b2b(k1, 4) : exp_vec(k1, 4));
    check($sformatf("%s c2 k=%0d", tag, k2), v2, b2b ? exp_b2b(k2, 2) : exp_vec(k2, 2));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Start one block in the current cycle (cycle 0) and check ncyc cycles afterwards.
  task automatic run_block(input string tag, input int ncyc);
    blk_valid = 1'b1;
    out_free = 1'b1;
    @(negedge clk);
    cmp(tag, 0, 0, 1'b0);
    nxt();
    blk_valid = 1'b0;
    out_free = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cmp(tag, k, k, 1'b0);
      if (k == 4)  check("t_wr first @4", {31'b0, t_wr}, 32'd1);
      if (k == 32) check("blk_ack @32", {31'b0, blk_ack}, 32'd1);
      if (k == 36) check("out_we first @36", {31'b0, out_we}, 32'd1);
      if (k == 64) check("out_col_addr @64", {29'b0, out_col_addr}, 32'd7);
      if (k == 65) check("done @65", {31'b0, done}, 32'd1);
      if (k == 66) check("busy low @66", {31'b0, busy}, 32'd0);
      if (k == 16) check("c2 last t_wr @16", {31'b0, t_wr2}, 32'd1);
      if (k == 33) check("c2 done @33", {31'b0, done2}, 32'd1);
      nxt();
    end
  endtask

  initial begin
    rst = 1'b1; blk_valid = 1'b0; out_free = 1'b0; abort = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    cmp("reset", 0, 0, 1'b0);
    nxt();
    rst = 1'b0;
    nxt();

    // single block
    run_block("single", 70);

    // gated start: blk_valid without out_free must stall
    blk_valid = 1'b1;
    out_free = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmp("stall", 0, 0, 1'b0);
      nxt();
    end
    run_block("gated", 70);

    // back-to-back
    blk_valid = 1'b1;
    out_free = 1'b1;
    nxt();
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      cmp("b2b", k, k, 1'b1);
      if (k == 69) check("b2b 2nd t_wr @69", {31'b0, t_wr}, 32'd1);
      nxt();
    end
    abort = 1'b1;
    blk_valid = 1'b0;
    out_free = 1'b0;
    @(negedge clk);
    cmp("b2b abort", 141, 141, 1'b1);
    nxt();
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("post b2b abort", 0, 0, 1'b0);
      nxt();
    end

    // abort at cycle 40 (PASS2, idx 1)
    blk_valid = 1'b1;
    out_free = 1'b1;
    nxt();
    blk_valid = 1'b0;
    out_free = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k == 40) abort = 1'b1;
      if (k == 41) abort = 1'b0;
      @(negedge clk);
      cmp("abort", (k <= 40) ? k : 0, k, 1'b0);
      nxt();
    end
    run_block("after abort", 70);

    // synchronous reset at cycle 20 of PASS1
    blk_valid = 1'b1;
    out_free = 1'b1;
    nxt();
    blk_valid = 1'b0;
    out_free = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 20) rst = 1'b1;
      if (k == 21) rst = 1'b0;
      @(negedge clk);
      cmp("midrst", (k <= 20) ? k : 0, (k <= 20) ? k : 0, 1'b0);
      nxt();
    end
    run_block("after rst", 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
